alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative shift-add
// multiply and restoring divide, one bit per cycle.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [3:0]           op_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 zero_o,
   output logic                 carry_o,
   output logic                 err_o
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_NAND = 4'd7;
   localparam logic [3:0] OP_NOR  = 4'd8;
   localparam logic [3:0] OP_NOT  = 4'd9;
   localparam logic [3:0] OP_SHL  = 4'd10;
   localparam logic [3:0] OP_SHR  = 4'd11;

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic                 isDiv_q, isDiv_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 carry_q, carry_d;
   logic                 err_q, err_d;

   logic [WIDTH:0]       opSum;
   logic [WIDTH-1:0]     opDiff;
   logic [2*WIDTH-1:0]   immResult;
   logic                 immCarry;
   logic                 immErr;
   logic [WIDTH:0]       mulSum;
   logic [WIDTH:0]       divShift;
   logic [WIDTH-1:0]     iterAcc;
   logic [WIDTH-1:0]     iterLo;

   always_comb begin
      opSum     = {1'b0, a_i} + {1'b0, b_i};
      opDiff    = a_i - b_i;
      immResult = '0;
      immCarry  = 1'b0;
      immErr    = 1'b0;
      case (op_i)
         OP_ADD: begin
            immResult = {{(WIDTH-1){1'b0}}, opSum};
            immCarry  = opSum[WIDTH];
         end
         OP_SUB: begin
            immResult = {{WIDTH{opDiff[WIDTH-1]}}, opDiff};
            immCarry  = (a_i < b_i);
         end
         OP_MUL:  immResult = '0;
         // Only reached for a zero divisor; nonzero divisors iterate
         OP_DIV: begin
            immResult = {a_i, {WIDTH{1'b1}}};
            immErr    = 1'b1;
         end
         OP_AND:  immResult = {{WIDTH{1'b0}}, a_i & b_i};
         OP_OR:   immResult = {{WIDTH{1'b0}}, a_i | b_i};
         OP_XOR:  immResult = {{WIDTH{1'b0}}, a_i ^ b_i};
         OP_NAND: immResult = {{WIDTH{1'b0}}, ~(a_i & b_i)};
         OP_NOR:  immResult = {{WIDTH{1'b0}}, ~(a_i | b_i)};
         OP_NOT:  immResult = {{WIDTH{1'b0}}, ~a_i};
         OP_SHL:  immResult = {{WIDTH{1'b0}}, a_i} << b_i;
         OP_SHR:  immResult = {{WIDTH{1'b0}}, a_i >> b_i};
         default: immErr    = 1'b1;
      endcase
   end

   // acc holds product high half / partial remainder; lo holds multiplier / quotient
   always_comb begin
      mulSum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      divShift = {acc_q, lo_q[WIDTH-1]};
      if (isDiv_q) begin
         if (divShift >= {1'b0, opnd_q}) begin
            iterAcc = WIDTH'(divShift - {1'b0, opnd_q});
            iterLo  = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            iterAcc = divShift[WIDTH-1:0];
            iterLo  = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         iterAcc = mulSum[WIDTH:1];
         iterLo  = {mulSum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      isDiv_d  = isDiv_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (op_i == OP_MUL || (op_i == OP_DIV && b_i != '0)) begin
                  state_d = ITER;
                  acc_d   = '0;
                  lo_d    = (op_i == OP_MUL) ? b_i : a_i;
                  opnd_d  = (op_i == OP_MUL) ? a_i : b_i;
                  isDiv_d = (op_i == OP_DIV);
                  cnt_d   = '0;
               end else begin
                  state_d  = DONE;
                  result_d = immResult;
                  zero_d   = (immResult == '0);
                  carry_d  = immCarry;
                  err_d    = immErr;
               end
            end
         end
         ITER: begin
            acc_d = iterAcc;
            lo_d  = iterLo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d  = DONE;
               result_d = {iterAcc, iterLo};
               zero_d   = ({iterAcc, iterLo} == '0);
               carry_d  = 1'b0;
               err_d    = 1'b0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         isDiv_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         isDiv_q  <= isDiv_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
      end
   end

   assign busy_o   = (state_q == ITER);
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;
   assign zero_o   = zero_q;
   assign carry_o  = carry_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8: table of single ops plus
// hand-written sequences for ignored starts and mid-iteration reset.
module tb_alu_seq;

   localparam int W = 8;

   logic          clk;
   logic          rst;
   logic          start;
   logic [3:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [2*W-1:0] result;
   logic          zero;
   logic          carry;
   logic          err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      logic        c;
      logic        e;
      logic        z;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   alu_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start),
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result),
      .zero_o   (zero),
      .carry_o  (carry),
      .err_o    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void addVec(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                                  input logic [15:0] r, input logic c, input logic e,
                                  input logic z, input int lat);
      vec_t v;
      v.op = o; v.a = va; v.b = vb; v.res = r; v.c = c; v.e = e; v.z = z; v.lat = lat;
      vecs.push_back(v);
   endfunction

   // Called at a negedge; start is seen by the next posedge, then operands are scrambled
   task automatic applyStimulus(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb);
      start = 1'b1;
      op    = o;
      a     = va;
      b     = vb;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      op    = 4'($urandom);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] expRes, input logic expC,
                              input logic expE, input logic expZ, input int expLat);
      int  cyc     = 0;
      int  busyCnt = 0;
      bit  seen    = 0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1;
         else if (busy) busyCnt++;
      end
      check({name, " latency"}, cyc, expLat);
      check({name, " busy cycles"}, busyCnt, expLat - 1);
      check({name, " result"}, {16'h0, result}, {16'h0, expRes});
      check({name, " carry"}, {31'h0, carry}, {31'h0, expC});
      check({name, " err"}, {31'h0, err}, {31'h0, expE});
      check({name, " zero"}, {31'h0, zero}, {31'h0, expZ});
      @(negedge clk);
      check({name, " hold"}, {15'h0, done, result}, {15'h0, 1'b0, expRes});
   endtask

   initial begin
      int doneCnt;
      logic [15:0] gotRes;

      addVec(4'd0,  8'hFF, 8'h01, 16'h0100, 1, 0, 0, 1);
      addVec(4'd0,  8'h00, 8'h00, 16'h0000, 0, 0, 1, 1);
      addVec(4'd1,  8'h03, 8'h05, 16'hFFFE, 1, 0, 0, 1);
      addVec(4'd1,  8'h05, 8'h03, 16'h0002, 0, 0, 0, 1);
      addVec(4'd2,  8'hFF, 8'hFF, 16'hFE01, 0, 0, 0, 9);
      addVec(4'd2,  8'h0C, 8'h0D, 16'h009C, 0, 0, 0, 9);
      addVec(4'd2,  8'h00, 8'h05, 16'h0000, 0, 0, 1, 9);
      addVec(4'd3,  8'h64, 8'h07, 16'h020E, 0, 0, 0, 9);
      addVec(4'd3,  8'h2A, 8'h00, 16'h2AFF, 0, 1, 0, 1);
      addVec(4'd3,  8'h05, 8'h09, 16'h0500, 0, 0, 0, 9);
      addVec(4'd3,  8'hFF, 8'h01, 16'h00FF, 0, 0, 0, 9);
      addVec(4'd4,  8'hF0, 8'h3C, 16'h0030, 0, 0, 0, 1);
      addVec(4'd5,  8'hF0, 8'h0F, 16'h00FF, 0, 0, 0, 1);
      addVec(4'd6,  8'hAA, 8'hFF, 16'h0055, 0, 0, 0, 1);
      addVec(4'd7,  8'hF0, 8'h0F, 16'h00FF, 0, 0, 0, 1);
      addVec(4'd8,  8'hF0, 8'h0F, 16'h0000, 0, 0, 1, 1);
      addVec(4'd9,  8'h5A, 8'h33, 16'h00A5, 0, 0, 0, 1);
      addVec(4'd10, 8'h81, 8'h04, 16'h0810, 0, 0, 0, 1);
      addVec(4'd10, 8'h01, 8'h0F, 16'h8000, 0, 0, 0, 1);
      addVec(4'd10, 8'h01, 8'h10, 16'h0000, 0, 0, 1, 1);
      addVec(4'd11, 8'h80, 8'h09, 16'h0000, 0, 0, 1, 1);
      addVec(4'd11, 8'h80, 8'h07, 16'h0001, 0, 0, 0, 1);
      addVec(4'd13, 8'h12, 8'h34, 16'h0000, 0, 1, 1, 1);
      addVec(4'd12, 8'hFF, 8'hFF, 16'h0000, 0, 1, 1, 1);

      rst   = 1'b1;
      start = 1'b0;
      op    = 4'd0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check("reset busy",   {31'h0, busy},  32'h0);
      check("reset done",   {31'h0, done},  32'h0);
      check("reset result", {16'h0, result}, 32'h0);
      check("reset zero",   {31'h0, zero},  32'h1);
      check("reset carry",  {31'h0, carry}, 32'h0);
      check("reset err",    {31'h0, err},   32'h0);

      // Release reset and request on the very first edge afterwards
      rst = 1'b0;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         checkOutput($sformatf("v%0d op%0d", i, vecs[i].op), vecs[i].res,
                     vecs[i].c, vecs[i].e, vecs[i].z, vecs[i].lat);
      end

      // Start while busy, and again during the done cycle, must both be ignored
      applyStimulus(4'd2, 8'h10, 8'h03);
      repeat (3) @(negedge clk);
      start = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01;
      @(posedge clk);
      #1 start = 1'b0;
      doneCnt = 0;
      gotRes  = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            doneCnt++;
            gotRes = result;
            start = 1'b1; op = 4'd0; a = 8'h07; b = 8'h07;
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
      check("busy start done count", doneCnt, 1);
      check("busy start result", {16'h0, gotRes}, 32'h0030);
      check("busy start held", {16'h0, result}, 32'h0030);

      // Reset in the middle of a divide aborts it
      applyStimulus(4'd3, 8'h64, 8'h07);
      repeat (4) @(negedge clk);
      check("div midway busy", {31'h0, busy}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("abort busy",   {31'h0, busy},  32'h0);
      check("abort done",   {31'h0, done},  32'h0);
      check("abort result", {16'h0, result}, 32'h0);
      check("abort zero",   {31'h0, zero},  32'h1);
      check("abort carry",  {31'h0, carry}, 32'h0);
      check("abort err",    {31'h0, err},   32'h0);
      @(negedge clk);
      rst = 1'b0;
      doneCnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) doneCnt++;
      end
      check("abort no done", doneCnt, 0);
      applyStimulus(4'd0, 8'h02, 8'h03);
      checkOutput("post-abort add", 16'h0005, 1'b0, 1'b0, 1'b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
